lcd_3wire_arbiter: RTL and testbench

LCD_3WIRE_ARBITER -- requirements
Module: lcd_3wire_arbiter

---
 rtl/lcd_3wire_pkg.sv | 32 +++
 rtl/lcd_3wire_rr_arb.sv | 27 ++
 rtl/lcd_3wire_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_lcd_3wire_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_3wire_pkg.sv
// Shared types and defaults for the three-wire LCD word arbiter.
// Holds the FSM state encoding, word field layout and counter sizing helper.
package lcd_3wire_pkg;

    localparam int ADDR_W = 6;
    localparam int RW_W   = 2;
    localparam int DATA_W = 8;
    localparam int WORD_W = ADDR_W + RW_W + DATA_W;

    localparam int DEF_MAX_RETRY  = 3;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RW_W-1:0]   rw;
        logic [DATA_W-1:0] data;
    } word_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lcd_3wire_rr_arb.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
// After reset the pointer favours requester 0.
module lcd_3wire_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       win,
    output logic       valid
);

    logic last_reg;

    always_comb begin
        valid = |req;
        win   = (req == 2'b11) ? ~last_reg : req[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (take && valid) begin
            last_reg <= win;
        end
    end

endmodule

// File: rtl/lcd_3wire_arbiter.sv
// Arbitrates two word sources onto one three-wire serial engine, with
// NACK/timeout retries, inter-word gap and a saturating error counter.
module lcd_3wire_arbiter
    import lcd_3wire_pkg::*;
#(
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iREQ0,
    input  logic              iREQ1,
    input  logic [WORD_W-1:0] iDATA0,
    input  logic [WORD_W-1:0] iDATA1,
    output logic              oGNT0,
    output logic              oGNT1,
    output logic              oDONE0,
    output logic              oDONE1,
    output logic              oERR0,
    output logic              oERR1,
    output logic              oSTR,
    output logic [WORD_W-1:0] oDATA,
    input  logic              iRDY,
    input  logic              iACK,
    output logic              oBUSY,
    output logic [7:0]        oERR_CNT
);

    localparam int RT_W = cnt_width(MAX_RETRY);
    localparam int GP_W = cnt_width(GAP_CYCLES);
    localparam int WD_W = cnt_width(TIMEOUT);

    state_t          state_reg, state_next;
    word_t           data_reg, data_next;
    logic            owner_reg, owner_next;
    logic [RT_W-1:0] retry_reg, retry_next;
    logic            pend_reg, pend_next;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic [GP_W-1:0] gap_reg, gap_next;
    logic            str_reg, str_next;
    logic            gnt_reg, gnt_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic [7:0]      err_cnt_reg, err_cnt_next;

    logic       fail;
    logic       take;
    logic       win;
    logic       win_valid;
    logic [1:0] req;
    logic [1:0] gnt_vec, done_vec, err_vec;

    assign req = {iREQ1, iREQ0};

    lcd_3wire_rr_arb u_arb (
        .clk   (iCLK),
        .rst   (iRST),
        .req   (req),
        .take  (take),
        .win   (win),
        .valid (win_valid)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_reg   <= ST_IDLE;
            data_reg    <= '0;
            owner_reg   <= 1'b0;
            retry_reg   <= '0;
            pend_reg    <= 1'b0;
            wd_reg      <= '0;
            gap_reg     <= '0;
            str_reg     <= 1'b0;
            gnt_reg     <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            owner_reg   <= owner_next;
            retry_reg   <= retry_next;
            pend_reg    <= pend_next;
            wd_reg      <= wd_next;
            gap_reg     <= gap_next;
            str_reg     <= str_next;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        owner_next   = owner_reg;
        retry_next   = retry_reg;
        pend_next    = pend_reg;
        wd_next      = wd_reg;
        gap_next     = gap_reg;
        str_next     = str_reg;
        err_cnt_next = err_cnt_reg;
        gnt_next     = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        take         = 1'b0;
        fail         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    take       = 1'b1;
                    data_next  = win ? word_t'(iDATA1) : word_t'(iDATA0);
                    owner_next = win;
                    gnt_next   = 1'b1;
                    retry_next = '0;
                    pend_next  = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                str_next   = 1'b1;
                wd_next    = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (iRDY) begin
                    str_next = 1'b0;
                    if (iACK) begin
                        done_next  = 1'b1;
                        gap_next   = '0;
                        state_next = ST_GAP;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                    str_next = 1'b0;
                    fail     = 1'b1;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_reg == GP_W'(GAP_CYCLES - 1)) begin
                    // A pending retry reissues the latched word without re-arbitrating.
                    if (pend_reg) begin
                        pend_next  = 1'b0;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    gap_next = gap_reg + GP_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (fail) begin
            gap_next   = '0;
            state_next = ST_GAP;
            if (retry_reg < RT_W'(MAX_RETRY)) begin
                retry_next = retry_reg + RT_W'(1);
                pend_next  = 1'b1;
            end else begin
                err_next = 1'b1;
                if (err_cnt_reg != 8'hFF) begin
                    err_cnt_next = err_cnt_reg + 8'd1;
                end
            end
        end
    end

    // Route the shared pulse registers to whichever requester owns the word.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_vec[gi]  = gnt_reg  && (owner_reg == 1'(gi));
            assign done_vec[gi] = done_reg && (owner_reg == 1'(gi));
            assign err_vec[gi]  = err_reg  && (owner_reg == 1'(gi));
        end
    endgenerate

    assign oGNT0    = gnt_vec[0];
    assign oGNT1    = gnt_vec[1];
    assign oDONE0   = done_vec[0];
    assign oDONE1   = done_vec[1];
    assign oERR0    = err_vec[0];
    assign oERR1    = err_vec[1];
    assign oSTR     = str_reg;
    assign oDATA    = data_reg;
    assign oBUSY    = (state_reg != ST_IDLE);
    assign oERR_CNT = err_cnt_reg;

endmodule

// File: tb/tb_lcd_3wire_arbiter.sv
// Directed bench for lcd_3wire_arbiter: a vector table of single words plus
// hand-written contention, reset, exhaustion and timeout sequences.
module tb_lcd_3wire_arbiter;

    localparam int MAX_RETRY  = 3;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 1023;

    logic        iCLK = 1'b0;
    logic        iRST, iREQ0, iREQ1, iRDY, iACK;
    logic [15:0] iDATA0, iDATA1, oDATA;
    logic        oGNT0, oGNT1, oDONE0, oDONE1, oERR0, oERR1, oSTR, oBUSY;
    logic [7:0]  oERR_CNT;

    always #5 iCLK = ~iCLK;

    lcd_3wire_arbiter #(
        .MAX_RETRY  (MAX_RETRY),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iREQ0    (iREQ0),
        .iREQ1    (iREQ1),
        .iDATA0   (iDATA0),
        .iDATA1   (iDATA1),
        .oGNT0    (oGNT0),
        .oGNT1    (oGNT1),
        .oDONE0   (oDONE0),
        .oDONE1   (oDONE1),
        .oERR0    (oERR0),
        .oERR1    (oERR1),
        .oSTR     (oSTR),
        .oDATA    (oDATA),
        .iRDY     (iRDY),
        .iACK     (iACK),
        .oBUSY    (oBUSY),
        .oERR_CNT (oERR_CNT)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: answers oSTR after eng_delay cycles, NACKing nack_left times first.
    int eng_delay = 1;
    int nack_left = 0;
    bit eng_off   = 1'b0;
    bit stray_rdy = 1'b0;

    initial begin
        int str_cnt;
        str_cnt = 0;
        iRDY = 1'b0;
        iACK = 1'b0;
        forever begin
            @(negedge iCLK);
            iRDY = stray_rdy;
            iACK = stray_rdy;
            if (oSTR && !eng_off) begin
                str_cnt++;
                if (str_cnt == eng_delay) begin
                    iRDY = 1'b1;
                    if (nack_left > 0) begin
                        iACK = 1'b0;
                        nack_left--;
                    end else begin
                        iACK = 1'b1;
                    end
                end
            end else if (!oSTR) begin
                str_cnt = 0;
            end
        end
    end

    // Monitor: pulse counters, strobe run lengths, protocol invariants.
    int n_gnt0 = 0, n_gnt1 = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0, n_str = 0;
    int viol_overlap = 0, viol_data = 0;
    int low_run = 0, high_run = 0, last_low_run = 0, last_high_run = 0;
    int cyc = 0, last_done_cyc = 0, done_to_gnt = 0;
    bit data_chk_en = 1'b0;
    int grant_log[$];

    initial begin
        logic        prev_str;
        logic [15:0] prev_data;
        prev_str  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge iCLK);
            cyc++;
            if (int'(oGNT0) + int'(oGNT1) + int'(oDONE0) + int'(oDONE1) + int'(oERR0) + int'(oERR1) > 1)
                viol_overlap++;
            if (oGNT0 || oGNT1) begin
                grant_log.push_back(oGNT1 ? 1 : 0);
                done_to_gnt = cyc - last_done_cyc;
            end
            if (oDONE0 || oDONE1) last_done_cyc = cyc;
            if (oGNT0)  n_gnt0++;
            if (oGNT1)  n_gnt1++;
            if (oDONE0) n_done0++;
            if (oDONE1) n_done1++;
            if (oERR0)  n_err0++;
            if (oERR1)  n_err1++;
            if (oSTR && !prev_str) begin
                n_str++;
                last_low_run = low_run;
                high_run = 0;
            end
            if (!oSTR && prev_str) begin
                last_high_run = high_run;
                low_run = 0;
            end
            if (oSTR) high_run++;
            else      low_run++;
            if (data_chk_en && oDATA !== prev_data && !oGNT0 && !oGNT1) viol_data++;
            prev_data = oDATA;
            prev_str  = oSTR;
        end
    end

    // Issue one word, drop requests on the first done/err, then wait for idle.
    task automatic run_word(input logic r0, input logic r1, input logic [15:0] d0,
                            input logic [15:0] d1, input int nacks, input int dly,
                            output int lat, output bit ok);
        nack_left = nacks;
        eng_delay = dly;
        iDATA0 = d0;
        iDATA1 = d1;
        iREQ0  = r0;
        iREQ1  = r1;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge iCLK);
            if (lat == 0 && oSTR) lat = i + 1;
            if (oDONE0 || oDONE1 || oERR0 || oERR1) ok = 1'b1;
        end
        iREQ0 = 1'b0;
        iREQ1 = 1'b0;
        for (int i = 0; i < 20 && oBUSY; i++) @(negedge iCLK);
        @(negedge iCLK);
        nack_left = 0;
    endtask

    typedef struct {
        bit          r0, r1;
        logic [15:0] d0, d1;
        int          nacks, dly;
        bit          who;
        logic [15:0] exp_data;
        int          exp_str;
        bit          exp_err;
        int          exp_ecnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        int lat, g0, g1, dn0, dn1, e0, e1, s;
        bit ok, re;
        int dones;

        vt[0] = '{1, 0, 16'h4501, 16'h0000, 0, 40, 0, 16'h4501, 1, 0, 0};
        vt[1] = '{0, 1, 16'h0000, 16'hA5C3, 0,  3, 1, 16'hA5C3, 1, 0, 0};
        vt[2] = '{1, 1, 16'h1234, 16'hBEEF, 0,  3, 0, 16'h1234, 1, 0, 0};
        vt[3] = '{1, 1, 16'h0F0F, 16'hF0F0, 0,  3, 1, 16'hF0F0, 1, 0, 0};
        vt[4] = '{0, 1, 16'h0000, 16'h7E81, 2,  3, 1, 16'h7E81, 3, 0, 0};
        vt[5] = '{1, 1, 16'hFFFF, 16'h0001, 1,  3, 0, 16'hFFFF, 2, 0, 0};
        vt[6] = '{1, 0, 16'h8001, 16'h0000, 4,  2, 0, 16'h8001, 4, 1, 1};
        vt[7] = '{1, 1, 16'h1111, 16'h2222, 0,  3, 1, 16'h2222, 1, 0, 1};

        iRST = 1'b1; iREQ0 = 1'b0; iREQ1 = 1'b0; iDATA0 = '0; iDATA1 = '0;
        repeat (3) @(negedge iCLK);
        check("reset_str",  32'(oSTR), 32'd0);
        check("reset_data", 32'(oDATA), 32'd0);
        check("reset_busy", 32'(oBUSY), 32'd0);
        check("reset_ecnt", 32'(oERR_CNT), 32'd0);
        check("reset_pulses", 32'({oGNT0, oGNT1, oDONE0, oDONE1, oERR0, oERR1}), 32'd0);
        iRST = 1'b0;
        @(negedge iCLK);
        data_chk_en = 1'b1;

        for (int v = 0; v < 8; v++) begin
            g0 = n_gnt0; g1 = n_gnt1; dn0 = n_done0; dn1 = n_done1; e0 = n_err0; e1 = n_err1; s = n_str;
            run_word(vt[v].r0, vt[v].r1, vt[v].d0, vt[v].d1, vt[v].nacks, vt[v].dly, lat, ok);
            $display("vec %0d: grants=%0d/%0d data=%h strobes=%0d done=%0d/%0d err=%0d/%0d err_cnt=%0d",
                     v, n_gnt0 - g0, n_gnt1 - g1, oDATA, n_str - s, n_done0 - dn0, n_done1 - dn1,
                     n_err0 - e0, n_err1 - e1, oERR_CNT);
            check($sformatf("vec%0d_finished", v), 32'(ok), 32'd1);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
            check($sformatf("vec%0d_gnt0", v), 32'(n_gnt0 - g0), vt[v].who ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_gnt1", v), 32'(n_gnt1 - g1), vt[v].who ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_data", v), 32'(oDATA), 32'(vt[v].exp_data));
            check($sformatf("vec%0d_strobes", v), 32'(n_str - s), 32'(vt[v].exp_str));
            check($sformatf("vec%0d_done", v), 32'((n_done0 - dn0) + (n_done1 - dn1)), vt[v].exp_err ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_err", v), 32'((vt[v].who ? n_err1 - e1 : n_err0 - e0)), vt[v].exp_err ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_err_cnt", v), 32'(oERR_CNT), 32'(vt[v].exp_ecnt));
            // A retry restarts after the gap plus the START cycle.
            if (vt[v].exp_str > 1)
                check($sformatf("vec%0d_retry_gap", v), 32'(last_low_run), 32'(GAP_CYCLES + 1));
        end

        // Contention: tie, then requester 0 comes back while 1 is being served.
        grant_log.delete();
        eng_delay = 3; nack_left = 0;
        iDATA0 = 16'hC001; iDATA1 = 16'hC002;
        iREQ0 = 1'b1; iREQ1 = 1'b1;
        re = 1'b0; dones = 0;
        for (int i = 0; i < 500 && dones < 3; i++) begin
            @(negedge iCLK);
            if (oDONE0) begin iREQ0 = 1'b0; dones++; end
            if (oDONE1) begin iREQ1 = 1'b0; dones++; end
            if (oGNT1 && !re) begin re = 1'b1; iDATA0 = 16'hC003; iREQ0 = 1'b1; end
        end
        iREQ0 = 1'b0; iREQ1 = 1'b0;
        repeat (6) @(negedge iCLK);
        $display("contention: dones=%0d grants=%0d done_to_gnt=%0d data=%h", dones, grant_log.size(), done_to_gnt, oDATA);
        check("cont_dones", 32'(dones), 32'd3);
        check("cont_ngrants", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("cont_order0", 32'(grant_log[0]), 32'd0);
            check("cont_order1", 32'(grant_log[1]), 32'd1);
            check("cont_order2", 32'(grant_log[2]), 32'd0);
        end
        // done -> GAP_CYCLES of gap -> IDLE sampling cycle -> grant
        check("cont_word_gap", 32'(done_to_gnt), 32'(GAP_CYCLES + 1));
        check("cont_data", 32'(oDATA), 32'hC003);

        // Stray iRDY/iACK while idle must be ignored.
        dn0 = n_done0; dn1 = n_done1;
        stray_rdy = 1'b1;
        repeat (5) @(negedge iCLK);
        $display("stray_rdy: busy=%0b str=%0b", oBUSY, oSTR);
        check("stray_busy", 32'(oBUSY), 32'd0);
        check("stray_str", 32'(oSTR), 32'd0);
        stray_rdy = 1'b0;
        @(negedge iCLK);
        check("stray_done", 32'((n_done0 - dn0) + (n_done1 - dn1)), 32'd0);

        // Reset mid-WAIT: grant 0 first so the pointer would otherwise favour 1.
        eng_off = 1'b1;
        iDATA0 = 16'hABCD; iREQ0 = 1'b1;
        for (int i = 0; i < 10 && !oSTR; i++) @(negedge iCLK);
        iREQ0 = 1'b0;
        repeat (5) @(negedge iCLK);
        check("rst_pre_str", 32'(oSTR), 32'd1);
        data_chk_en = 1'b0;
        dn0 = n_done0; e0 = n_err0;
        #2 iRST = 1'b1;
        #1;
        $display("reset mid-wait: str=%0b busy=%0b data=%h err_cnt=%0d", oSTR, oBUSY, oDATA, oERR_CNT);
        check("rst_async_str", 32'(oSTR), 32'd0);
        check("rst_async_busy", 32'(oBUSY), 32'd0);
        check("rst_async_data", 32'(oDATA), 32'd0);
        check("rst_async_ecnt", 32'(oERR_CNT), 32'd0);
        #1 iRST = 1'b0;
        repeat (5) @(negedge iCLK);
        check("rst_no_pulse", 32'((n_done0 - dn0) + (n_err0 - e0)), 32'd0);
        data_chk_en = 1'b1;
        eng_off = 1'b0;
        g0 = n_gnt0;
        run_word(1'b1, 1'b1, 16'hD0D0, 16'hD1D1, 0, 3, lat, ok);
        $display("post-reset tie: grant0=%0d data=%h", n_gnt0 - g0, oDATA);
        check("rst_tie_gnt0", 32'(n_gnt0 - g0), 32'd1);
        check("rst_tie_data", 32'(oDATA), 32'hD0D0);

        // Exhaustion: every attempt NACKed, error counter saturates at 255.
        for (int w = 0; w < 260; w++) begin
            dn1 = n_done1; e1 = n_err1; s = n_str;
            run_word(1'b0, 1'b1, 16'h0000, 16'(32'h5A00 + w), 4, 1, lat, ok);
            $display("exhaust %0d: strobes=%0d err1=%0d err_cnt=%0d", w, n_str - s, n_err1 - e1, oERR_CNT);
            if (w == 0) begin
                check("exh_strobes", 32'(n_str - s), 32'(MAX_RETRY + 1));
                check("exh_err1", 32'(n_err1 - e1), 32'd1);
                check("exh_done1", 32'(n_done1 - dn1), 32'd0);
                check("exh_ecnt1", 32'(oERR_CNT), 32'd1);
            end
            if (w == 253) check("exh_ecnt254", 32'(oERR_CNT), 32'd254);
            if (w == 254) check("exh_ecnt255", 32'(oERR_CNT), 32'd255);
        end
        check("exh_ecnt_sat", 32'(oERR_CNT), 32'd255);

        // Timeout: engine silent, each attempt lasts TIMEOUT cycles of oSTR.
        eng_off = 1'b1;
        dn1 = n_done1; e1 = n_err1; s = n_str;
        run_word(1'b0, 1'b1, 16'h0000, 16'h3C5A, 0, 1, lat, ok);
        $display("timeout: finished=%0b strobes=%0d high_run=%0d err1=%0d err_cnt=%0d",
                 ok, n_str - s, last_high_run, n_err1 - e1, oERR_CNT);
        check("to_finished", 32'(ok), 32'd1);
        check("to_strobes", 32'(n_str - s), 32'(MAX_RETRY + 1));
        check("to_high_run", 32'(last_high_run), 32'(TIMEOUT));
        check("to_err1", 32'(n_err1 - e1), 32'd1);
        check("to_done1", 32'(n_done1 - dn1), 32'd0);
        check("to_ecnt", 32'(oERR_CNT), 32'd255);
        eng_off = 1'b0;

        check("pulse_overlap", 32'(viol_overlap), 32'd0);
        check("data_stable", 32'(viol_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
